// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory and
// write-back with an MIO_ready wait handshake, optional timeout and sticky ERR trap.
module mcpu_ctrl_fsm #(
    parameter int MIO_TIMEOUT = 0,
    parameter int STATE_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         OPcode,
    input  logic [5:0]         Fun,
    input  logic               zero,
    input  logic               MIO_ready,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               CPU_MIO,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [2:0]         ALU_Control,
    output logic               bus_err,
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_MEM = 5'd2,
        S_MEM_RD = 5'd3,
        S_MEM_WR = 5'd4,
        S_WB_LW  = 5'd5,
        S_EX_R   = 5'd6,
        S_WB_R   = 5'd7,
        S_BR     = 5'd8,
        S_J      = 5'd9,
        S_JAL    = 5'd10,
        S_JR     = 5'd11,
        S_EX_I   = 5'd12,
        S_WB_I   = 5'd13,
        S_LUI    = 5'd14,
        S_ERR    = 5'd31
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int CNT_W = (MIO_TIMEOUT > 1) ? $clog2(MIO_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MIO_TIMEOUT > 0) ? CNT_W'(MIO_TIMEOUT - 1) : '0;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             timeout_hit;

    function automatic logic r_fun_valid(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b000010: r_fun_valid = 1'b1;
            default:                                    r_fun_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b000010: r_alu = ALU_SRL;
            default:   r_alu = ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_XORI: i_alu = ALU_XOR;
            OP_SLTI: i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    endfunction

    // Counter is zero on every entry to a wait state because it clears whenever
    // an access completes or the FSM is elsewhere.
    assign in_wait     = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = (MIO_TIMEOUT > 0) && in_wait && !MIO_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IF;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if ((MIO_TIMEOUT > 0) && in_wait && !MIO_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IF: begin
                if (timeout_hit)    state_next = S_ERR;
                else if (MIO_ready) state_next = S_ID;
            end
            S_ID: begin
                case (OPcode)
                    OP_LW, OP_SW:   state_next = S_EX_MEM;
                    OP_BEQ, OP_BNE: state_next = S_BR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_next = S_EX_I;
                    OP_LUI:         state_next = S_LUI;
                    OP_J:           state_next = S_J;
                    OP_JAL:         state_next = S_JAL;
                    OP_RTYPE: begin
                        if ((Fun == FN_JR) || (Fun == FN_JALR)) state_next = S_JR;
                        else if (r_fun_valid(Fun))              state_next = S_EX_R;
                        else                                    state_next = S_IF;
                    end
                    default:        state_next = S_IF;
                endcase
            end
            S_EX_MEM: begin
                if (OPcode == OP_LW)      state_next = S_MEM_RD;
                else if (OPcode == OP_SW) state_next = S_MEM_WR;
                else                      state_next = S_IF;
            end
            S_MEM_RD: begin
                if (timeout_hit)    state_next = S_ERR;
                else if (MIO_ready) state_next = S_WB_LW;
            end
            S_MEM_WR: begin
                if (timeout_hit)    state_next = S_ERR;
                else if (MIO_ready) state_next = S_IF;
            end
            S_EX_R:  state_next = S_WB_R;
            S_EX_I:  state_next = S_WB_I;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IF;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        CPU_MIO     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALU_Control = ALU_ADD;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID: ALUSrcB = 2'b11;
            S_EX_MEM: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
            end
            S_WB_LW: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_EX_R: begin
                ALUSrcA     = 1'b1;
                ALU_Control = r_alu(Fun);
            end
            S_WB_R: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_EX_I: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_Control = i_alu(OPcode);
            end
            S_WB_I: RegWrite = 1'b1;
            S_LUI: begin
                MemtoReg = 2'b11;
                RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSource    = 2'b01;
                PCWrite     = (OPcode == OP_BNE) ? ~zero : zero;
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                if (Fun == FN_JALR) begin
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus_err   = (state == S_ERR);
    assign state_out = STATE_W'(state);

endmodule
